// File: rtl/filters_sample_feeder.sv
// Sample feeder ahead of the filters block: a small circular FIFO filled by a
// valid/ready producer and drained at a fixed pace with no output backpressure.
module filters_sample_feeder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int PACE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         x,
  output logic                     x_is_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    pace_q, pace_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             xv_q, xv_d;
  logic             tick_s, wr_s, rd_s, ready_s;

  assign ready_s    = !flush && (count_q < CW'(DEPTH));
  assign tick_s     = (pace_q == PW'(PACE - 1));
  assign wr_s       = in_valid && ready_s;
  assign rd_s       = tick_s && (count_q != {CW{1'b0}}) && !flush;

  assign in_ready   = ready_s;
  assign x          = x_q;
  assign x_is_valid = xv_q;
  assign count      = count_q;

  // Free-running slot divider; keeps counting through empty slots and flushes.
  always_comb begin
    pace_d = pace_q;
    if (tick_s) begin
      pace_d = {PW{1'b0}};
    end else begin
      pace_d = pace_q + PW'(1);
    end
  end

  // FIFO pointer, occupancy and output next-state; a read never sees a same-edge write.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    x_d      = x_q;
    xv_d     = 1'b0;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (wr_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        x_d      = mem_q[rd_ptr_q];
        xv_d     = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_s, rd_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sample storage; left uninitialised because reset makes every entry unreachable.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      pace_q   <= {PW{1'b0}};
      x_q      <= {WIDTH{1'b0}};
      xv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pace_q   <= pace_d;
      x_q      <= x_d;
      xv_q     <= xv_d;
    end
  end

endmodule

// File: tb/tb_filters_sample_feeder.sv
// Drives three feeders (PACE 1, 2, 4) from shared stimulus and checks each
// against a queue-based model of the feeder's slot/occupancy rules.
module tb_filters_sample_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [3:0] in_data;
  logic       rdy_s [3];
  logic [3:0] x_s   [3];
  logic       v_s   [3];
  logic [2:0] cnt_s [3];

  int         pace_tab [3] = '{1, 2, 4};
  logic [3:0] mq [3][$];
  logic [3:0] ex [3];
  logic       ev [3];
  int         cyc;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    filters_sample_feeder #(
      .WIDTH(4), .DEPTH(4), .PACE((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_s[g]), .x(x_s[g]), .x_is_valid(v_s[g]), .count(cnt_s[g])
    );
  end

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      ex[k] = 4'h0;
      ev[k] = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    in_data = 4'h0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock edge: apply inputs, advance the model at the edge, return at negedge.
  task automatic step(input logic v, input logic [3:0] d, input logic f);
    int sz;
    bit tk, rd, wr;
    in_valid = v;
    in_data = d;
    flush = f;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      sz = mq[k].size();
      tk = (cyc % pace_tab[k]) == (pace_tab[k] - 1);
      rd = tk && (sz > 0) && !f;
      wr = v && !f && (sz < 4);
      ev[k] = rd;
      if (rd) ex[k] = mq[k].pop_front();
      if (f) mq[k].delete();
      if (wr) mq[k].push_back(d);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b1;
    in_data = 4'h9;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (x_s[k] !== 4'h0 || v_s[k] !== 1'b0 || cnt_s[k] !== 3'd0 || rdy_s[k] !== 1'b1) begin
          bad++;
          $display("FAIL reset p=%0d x=%h v=%b cnt=%0d rdy=%b, want 0 0 0 1",
                   pace_tab[k], x_s[k], v_s[k], cnt_s[k], rdy_s[k]);
        end
      end
    end
    in_valid = 1'b0;
    model_clear();
    rst = 1'b1;
  endtask

  task automatic test_pace1();
    logic [3:0] d [5] = '{4'h5, 4'h7, 4'h4, 4'h8, 4'hF};
    do_reset();
    for (int j = 0; j < 9; j++) begin
      if (j < 5) step(1'b1, d[j], 1'b0);
      else step(1'b0, 4'h0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (x_s[k] !== ex[k] || v_s[k] !== ev[k] || cnt_s[k] !== 3'(mq[k].size()) ||
            rdy_s[k] !== (!flush && mq[k].size() < 4)) begin
          bad++;
          $display("FAIL pace1 p=%0d x=%h/%h v=%b/%b cnt=%0d/%0d rdy=%b (got/want)",
                   pace_tab[k], x_s[k], ex[k], v_s[k], ev[k], cnt_s[k], mq[k].size(), rdy_s[k]);
        end
      end
      total++;
      if (v_s[0] !== (j >= 1 && j <= 5) || (j >= 1 && j <= 5 && x_s[0] !== d[j-1]) || cnt_s[0] > 3'd1) begin
        bad++;
        $display("FAIL pace1_seq step=%0d v=%b x=%h cnt=%0d", j, v_s[0], x_s[0], cnt_s[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] idx = 4'd1;
    logic [3:0] got [$];
    bit acc;
    do_reset();
    for (int j = 0; j < 30; j++) begin
      acc = (idx <= 4'd6) && rdy_s[2];
      step(idx <= 4'd6, idx, 1'b0);
      if (acc) idx++;
      if (v_s[2]) got.push_back(x_s[2]);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (x_s[k] !== ex[k] || v_s[k] !== ev[k] || cnt_s[k] !== 3'(mq[k].size()) ||
            rdy_s[k] !== (!flush && mq[k].size() < 4)) begin
          bad++;
          $display("FAIL backpressure p=%0d x=%h/%h v=%b/%b cnt=%0d/%0d rdy=%b (got/want)",
                   pace_tab[k], x_s[k], ex[k], v_s[k], ev[k], cnt_s[k], mq[k].size(), rdy_s[k]);
        end
      end
      total++;
      if (v_s[2] && (cyc % 4) != 0) begin
        bad++;
        $display("FAIL bp_slot output at edge %0d, want only every 4th edge", cyc - 1);
      end
    end
    total++;
    if (got.size() != 6 || got[0] !== 4'h1 || got[5] !== 4'h6) begin
      bad++;
      $display("FAIL bp_order got %0d outputs, first=%h last=%h, want 6 from 1 to 6",
               got.size(), (got.size() > 0) ? got[0] : 4'hx, (got.size() > 0) ? got[got.size()-1] : 4'hx);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] sent [$];
    logic [3:0] got [$];
    int pre;
    bit v, tk;
    logic [3:0] d;
    do_reset();
    for (int j = 0; j < 40; j++) begin
      pre = mq[1].size();
      tk = (cyc % 2) == 1;
      v = (j < 30) && ((pre < 2) || tk);
      d = 4'($urandom);
      if (v && pre < 4) sent.push_back(d);
      step(v, d, 1'b0);
      if (v_s[1]) got.push_back(x_s[1]);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (x_s[k] !== ex[k] || v_s[k] !== ev[k] || cnt_s[k] !== 3'(mq[k].size()) ||
            rdy_s[k] !== (!flush && mq[k].size() < 4)) begin
          bad++;
          $display("FAIL wrap p=%0d x=%h/%h v=%b/%b cnt=%0d/%0d rdy=%b (got/want)",
                   pace_tab[k], x_s[k], ex[k], v_s[k], ev[k], cnt_s[k], mq[k].size(), rdy_s[k]);
        end
      end
      if (pre == 2 && tk && v) begin
        total++;
        if (cnt_s[1] !== 3'd2) begin
          bad++;
          $display("FAIL wrap_rw count=%0d after read+write at 2, want 2", cnt_s[1]);
        end
      end
    end
    total++;
    if (got != sent) begin
      bad++;
      $display("FAIL wrap_order got %0d samples, sent %0d, sequences differ", got.size(), sent.size());
    end
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    do_reset();
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rdy_s[k] !== 1'b0) begin
        bad++;
        $display("FAIL flush_ready p=%0d in_ready=%b, want 0", pace_tab[k], rdy_s[k]);
      end
    end
    step(1'b1, 4'hB, 1'b1);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cnt_s[k] !== 3'd0 || v_s[k] !== 1'b0 || x_s[k] !== ex[k]) begin
        bad++;
        $display("FAIL flush_clear p=%0d cnt=%0d v=%b x=%h, want 0 0 %h",
                 pace_tab[k], cnt_s[k], v_s[k], x_s[k], ex[k]);
      end
    end
    step(1'b1, 4'hA, 1'b0);
    for (int j = 0; j < 8 && !seen; j++) begin
      if (j > 0) step(1'b0, 4'h0, 1'b0);
      if (v_s[2]) begin
        seen = 1'b1;
        total++;
        if (x_s[2] !== 4'hA) begin
          bad++;
          $display("FAIL flush_next x=%h, want a", x_s[2]);
        end
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL flush_next no output within 8 cycles, want a");
    end
  endtask

  task automatic test_midreset();
    bit seen = 1'b0;
    do_reset();
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cnt_s[k] !== 3'd0 || v_s[k] !== 1'b0 || x_s[k] !== 4'h0) begin
        bad++;
        $display("FAIL midreset p=%0d cnt=%0d v=%b x=%h, want 0 0 0",
                 pace_tab[k], cnt_s[k], v_s[k], x_s[k]);
      end
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 4'hC, 1'b0);
    for (int j = 0; j < 8 && !seen; j++) begin
      if (j > 0) step(1'b0, 4'h0, 1'b0);
      if (v_s[2]) begin
        seen = 1'b1;
        total++;
        if (x_s[2] !== 4'hC) begin
          bad++;
          $display("FAIL midreset_first x=%h, want c", x_s[2]);
        end
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL midreset_first no output within 8 cycles, want c");
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int j = 0; j < 300; j++) begin
      step(($urandom % 4) != 0, 4'($urandom), ($urandom % 32) == 0);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (x_s[k] !== ex[k] || v_s[k] !== ev[k] || cnt_s[k] !== 3'(mq[k].size()) ||
            rdy_s[k] !== (!flush && mq[k].size() < 4)) begin
          bad++;
          $display("FAIL random p=%0d x=%h/%h v=%b/%b cnt=%0d/%0d rdy=%b (got/want)",
                   pace_tab[k], x_s[k], ex[k], v_s[k], ev[k], cnt_s[k], mq[k].size(), rdy_s[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = 4'h0;
    model_clear();
    test_reset();
    test_pace1();
    test_backpressure();
    test_wrap();
    test_flush();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filters_sample_feeder.md
Name: filters_sample_feeder

Overview:
- Upstream stage of the `filters` block: buffers 4-bit samples from a producer and presents them to `filters` as `x` / `x_is_valid`.
- Producer side uses a valid/ready handshake into a small circular FIFO.
- Output side has no backpressure, because `filters` cannot stall; samples are released at a fixed pace set by a free-running rate divider.

Parameters:
- WIDTH, 4, sample width; must match `filters.x`.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- PACE, 1, clock cycles per output slot; ≥1. PACE=1 gives one slot every cycle.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-low reset; 0 = reset asserted.
- flush  input  1  synchronous clear of FIFO contents.
- in_data  input  WIDTH  producer sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept a sample this cycle.
- x  output  WIDTH  sample to `filters`; registered.
- x_is_valid  output  1  x carries a new sample this cycle; registered; one-cycle strobe per sample.
- count  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, takes effect immediately, independent of clk):
  - x=0, x_is_valid=0, count=0.
  - Read/write pointers = 0, pace counter = 0.
  - Memory contents need not be cleared; they are unreachable after reset.
- Reset release: the first rising edge with rst=1 is a normal operating edge.
- in_ready = !flush && (count < DEPTH). Combinational from registered count and flush.
- Write: occurs on an edge where in_valid && in_ready.
  - in_data is stored at wr_ptr; wr_ptr increments modulo DEPTH.
- Pace counter: free-running 0..PACE-1, wraps to 0.
  - tick = (pace_cnt == PACE-1); tick is high every cycle when PACE=1.
  - Never stalls, including when the FIFO is empty.
- Read: occurs on an edge where tick && count>0 && !flush. count is the value before the edge.
  - x <= mem[rd_ptr], x_is_valid <= 1, rd_ptr increments modulo DEPTH.
- No read on an edge: x_is_valid <= 0 and x holds its last value.
- An empty slot is lost: the tick is consumed, there is no output, and there is no catch-up.
- No fall-through: a sample written at edge N is readable at edge N+1 at the earliest.
  - Minimum latency is in_valid&&in_ready at edge N to x_is_valid high after edge N+1 (PACE=1, FIFO empty).
- count update per edge:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- Full (count=DEPTH): in_ready=0 and the write is refused even if a read happens on the same edge (no write bypass). The producer must hold in_data/in_valid.
- Empty (count=0): no read; x_is_valid stays 0.
- Simultaneous read and write at 0<count<DEPTH: both happen and count is unchanged.
- Pointer wrap: ordering is preserved across wrap; the output sequence exactly equals the accepted input sequence.
- flush=1 at an edge:
  - Pointers reset to 0, count <= 0, x_is_valid <= 0, x holds.
  - No write (in_ready already 0) and no read.
  - The pace counter keeps running.
- Reset mid-stream: all buffered samples are discarded. After release, only samples written after release appear on x.

Test Plan:
1. Hold rst=0, toggle clk with in_valid=1 → x=0, x_is_valid=0, count=0 throughout. in_ready=1 while count=0 and flush=0, but no write occurs.
2. PACE=1: write 0x5,0x7,0x4,0x8,0xF on consecutive edges → x_is_valid high for 5 consecutive cycles with x=0x5,0x7,0x4,0x8,0xF, each one edge after its write; count peaks at 1.
3. PACE=4, DEPTH=4: hold in_valid with 6 samples 0x1..0x6 back-to-back.
   - in_ready drops once count=4.
   - Outputs appear exactly every 4th cycle, in order 0x1..0x6.
   - The held 5th and 6th samples are accepted in the cycles after reads, never while count=4.
4. PACE=2: let count reach 2, then write on a tick edge → count stays 2 and x shows the oldest entry. Continue through 8+ writes → pointer wrap with correct order.
5. Fill to count=3, assert flush with in_valid=1 → in_ready=0 that cycle, count=0 next edge, no x_is_valid. The next written 0xA is the next sample output.
6. Mid-stream with count=2, pulse rst low between edges → count and x_is_valid drop to 0 immediately. After release, write 0xC → first output is 0xC.
